// File: rtl/mp_pwr_chg_pkg.sv
// Shared encodings and defaults for the per-lane power-state change sequencer.
package mp_pwr_chg_pkg;

  localparam int CNT_W       = 12;
  localparam int ACK_TMO_DEF = 2000;
  localparam int MIN_GAP_DEF = 8;

  localparam logic [1:0] P0 = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
  localparam logic [1:0] P3 = 2'b11;

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT_ACK1 = 3'd2,
    ST_WAIT_ACK0 = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

endpackage

// File: rtl/mp_pwr_chg_cnt.sv
// Loadable saturating down-counter; tc is high for the one cycle the count sits at 1.
module mp_pwr_chg_cnt
  import mp_pwr_chg_pkg::*;
(
  input  logic             psm_clk,
  input  logic             psm_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge psm_clk or negedge psm_rst_n) begin
    if (!psm_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(1));

endmodule

// File: rtl/mp_pwr_chg_ctrl_usb4.sv
// Per-lane PowerDown change sequencer running a four-phase req/ack with analog.
// Optional ack timeout is enabled by defining MP_PWR_CHG_ACK_TMO_EN.
module mp_pwr_chg_ctrl_usb4
  import mp_pwr_chg_pkg::*;
#(
  parameter int         ACK_TMO = ACK_TMO_DEF,
  parameter int         MIN_GAP = MIN_GAP_DEF,
  parameter logic [1:0] PD_RST  = P2
) (
  input  logic       psm_clk,
  input  logic       psm_rst_n,
  input  logic [1:0] pipe_powerdown,
  input  logic       lane_startup_done,
  input  logic       ana_pd_ack,
  output logic [1:0] ana_pd_req,
  output logic       ana_pd_req_vld,
  output logic [1:0] cur_pd,
  output logic       pwr_chg_busy,
  output logic       pwr_chg_done,
  output logic       ack_tmo_err
);

  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(MIN_GAP);

  state_t state;
  logic   gap_load;
  logic   gap_tc;
  logic   tmo_hit;

`ifdef MP_PWR_CHG_ACK_TMO_EN
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(ACK_TMO);
  logic tmo_load;
  logic tmo_tc;

  // Restart the ack timer whenever a WAIT state is entered.
  assign tmo_load = ((state == ST_IDLE) && (pipe_powerdown != cur_pd)) ||
                    ((state == ST_WAIT_ACK1) && ana_pd_ack);

  mp_pwr_chg_cnt u_tmo_cnt (
    .psm_clk   (psm_clk),
    .psm_rst_n (psm_rst_n),
    .load      (tmo_load),
    .load_val  (TMO_LD),
    .tc        (tmo_tc)
  );

  assign tmo_hit = tmo_tc;
`else
  assign tmo_hit = 1'b0;
`endif

  // Gap timer starts on every pwr_chg_done edge (startup assert or completion).
  assign gap_load = ((state == ST_STARTUP) && lane_startup_done) ||
                    ((state == ST_WAIT_ACK1) && !ana_pd_ack && tmo_hit) ||
                    ((state == ST_WAIT_ACK0) && (!ana_pd_ack || tmo_hit));

  mp_pwr_chg_cnt u_gap_cnt (
    .psm_clk   (psm_clk),
    .psm_rst_n (psm_rst_n),
    .load      (gap_load),
    .load_val  (GAP_LD),
    .tc        (gap_tc)
  );

  // NOTE: the asynchronous reset clears the request valid immediately, so the
  // analog side never sees a stale request while the lane is held in reset.
  always_ff @(posedge psm_clk or negedge psm_rst_n) begin
    if (!psm_rst_n) begin
      state          <= ST_STARTUP;
      ana_pd_req     <= PD_RST;
      ana_pd_req_vld <= 1'b0;
      cur_pd         <= PD_RST;
      pwr_chg_busy   <= 1'b0;
      pwr_chg_done   <= 1'b0;
      ack_tmo_err    <= 1'b0;
    end else begin
      case (state)
        ST_STARTUP: begin
          cur_pd     <= pipe_powerdown;
          ana_pd_req <= pipe_powerdown;
          if (lane_startup_done) begin
            pwr_chg_done <= 1'b1;
            state        <= ST_GAP;
          end
        end
        ST_IDLE: begin
          if (pipe_powerdown != cur_pd) begin
            ana_pd_req     <= pipe_powerdown;
            ana_pd_req_vld <= 1'b1;
            pwr_chg_busy   <= 1'b1;
            state          <= ST_WAIT_ACK1;
          end
        end
        ST_WAIT_ACK1: begin
          if (ana_pd_ack) begin
            ana_pd_req_vld <= 1'b0;
            state          <= ST_WAIT_ACK0;
          end else if (tmo_hit) begin
            ack_tmo_err    <= 1'b1;
            ana_pd_req_vld <= 1'b0;
            cur_pd         <= ana_pd_req;
            pwr_chg_done   <= ~pwr_chg_done;
            state          <= ST_GAP;
          end
        end
        ST_WAIT_ACK0: begin
          if (!ana_pd_ack || tmo_hit) begin
            // A genuine ack release wins over a coincident timeout.
            if (ana_pd_ack) begin
              ack_tmo_err <= 1'b1;
            end
            ana_pd_req_vld <= 1'b0;
            cur_pd         <= ana_pd_req;
            pwr_chg_done   <= ~pwr_chg_done;
            state          <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_tc) begin
            pwr_chg_busy <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_STARTUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_pwr_chg_ctrl_usb4.sv
// Directed bench for mp_pwr_chg_ctrl_usb4 (ACK_TMO=16, MIN_GAP=8, PD_RST=2'b10).
module tb_mp_pwr_chg_ctrl_usb4;

  localparam int         ACK_TMO = 16;
  localparam int         MIN_GAP = 8;
  localparam logic [1:0] PD_RST  = 2'b10;

  logic       psm_clk;
  logic       psm_rst_n;
  logic [1:0] pipe_powerdown;
  logic       lane_startup_done;
  logic       ana_pd_ack;
  logic [1:0] ana_pd_req;
  logic       ana_pd_req_vld;
  logic [1:0] cur_pd;
  logic       pwr_chg_busy;
  logic       pwr_chg_done;
  logic       ack_tmo_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mp_pwr_chg_ctrl_usb4 #(
    .ACK_TMO (ACK_TMO),
    .MIN_GAP (MIN_GAP),
    .PD_RST  (PD_RST)
  ) dut (
    .psm_clk           (psm_clk),
    .psm_rst_n         (psm_rst_n),
    .pipe_powerdown    (pipe_powerdown),
    .lane_startup_done (lane_startup_done),
    .ana_pd_ack        (ana_pd_ack),
    .ana_pd_req        (ana_pd_req),
    .ana_pd_req_vld    (ana_pd_req_vld),
    .cur_pd            (cur_pd),
    .pwr_chg_busy      (pwr_chg_busy),
    .pwr_chg_done      (pwr_chg_done),
    .ack_tmo_err       (ack_tmo_err)
  );

  initial psm_clk = 1'b0;
  always #5 psm_clk = ~psm_clk;

  always @(posedge psm_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge psm_clk);
    #1;
  endtask

  // Caller is positioned on a cycle where vld is already high. Ack rises after
  // d1 further cycles, falls d0 cycles later; returns on the completion edge.
  task automatic ack_seq(input int d1, input int d0, output int vld_cnt);
    vld_cnt = 0;
    for (int i = 0; i < d1; i++) begin
      vld_cnt += int'(ana_pd_req_vld);
      step();
    end
    vld_cnt += int'(ana_pd_req_vld);
    ana_pd_ack = 1'b1;
    step();
    for (int i = 1; i < d0; i++) step();
    ana_pd_ack = 1'b0;
    step();
  endtask

  task automatic wait_vld(input int budget);
    int n;
    n = 0;
    while (!ana_pd_req_vld && n < budget) begin
      step();
      n++;
    end
    check("vld_wait", 32'(ana_pd_req_vld), 32'd1);
  endtask

  initial begin
    int n;
    int c1;

    psm_rst_n         = 1'b0;
    pipe_powerdown    = 2'b00;
    lane_startup_done = 1'b0;
    ana_pd_ack        = 1'b0;

    // Reset values
    #23;
    check("rst_req",  32'(ana_pd_req),     32'(PD_RST));
    check("rst_vld",  32'(ana_pd_req_vld), 32'd0);
    check("rst_cur",  32'(cur_pd),         32'(PD_RST));
    check("rst_busy", 32'(pwr_chg_busy),   32'd0);
    check("rst_done", 32'(pwr_chg_done),   32'd0);
    check("rst_err",  32'(ack_tmo_err),    32'd0);

    // Startup: cur_pd tracks pipe_powerdown until lane_startup_done
    @(negedge psm_clk);
    psm_rst_n = 1'b1;
    step();
    check("su_cur_follow", 32'(cur_pd),     32'd0);
    check("su_req_follow", 32'(ana_pd_req), 32'd0);
    repeat (18) step();
    check("su_done_low", 32'(pwr_chg_done), 32'd0);
    lane_startup_done = 1'b1;
    step();
    check("su_done_rise", 32'(pwr_chg_done), 32'd1);
    check("su_busy",      32'(pwr_chg_busy), 32'd0);

    // Request 00->10 during gap; lane_startup_done drop must be harmless
    pipe_powerdown    = 2'b10;
    lane_startup_done = 1'b0;
    repeat (MIN_GAP) step();
    check("gap_no_vld", 32'(ana_pd_req_vld), 32'd0);
    step();
    check("p10_vld",  32'(ana_pd_req_vld), 32'd1);
    check("p10_req",  32'(ana_pd_req),     32'd2);
    check("p10_busy", 32'(pwr_chg_busy),   32'd1);
    ack_seq(5, 5, n);
    check("p10_vld_cycles", 32'(n),              32'd6);
    check("p10_cur",        32'(cur_pd),         32'd2);
    check("p10_toggle",     32'(pwr_chg_done),   32'd0);
    check("p10_vld_low",    32'(ana_pd_req_vld), 32'd0);
    check("p10_err",        32'(ack_tmo_err),    32'd0);
    repeat (MIN_GAP - 1) step();
    check("p10_busy_gap", 32'(pwr_chg_busy), 32'd1);
    step();
    check("p10_busy_end", 32'(pwr_chg_busy), 32'd0);

    // Rewrite with the value already in effect: nothing happens
    pipe_powerdown = 2'b10;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n += int'(ana_pd_req_vld);
    end
    check("eq_no_vld",  32'(n),            32'd0);
    check("eq_no_tgl",  32'(pwr_chg_done), 32'd0);

    // 10->11, then 01 while busy: two sequences back to back
    pipe_powerdown = 2'b11;
    step();
    check("p11_latency", 32'(ana_pd_req_vld), 32'd1);
    check("p11_req",     32'(ana_pd_req),     32'd3);
    step();
    pipe_powerdown = 2'b01;
    ack_seq(3, 3, n);
    check("p11_cur",    32'(cur_pd),       32'd3);
    check("p11_toggle", 32'(pwr_chg_done), 32'd1);
    check("p11_req_held", 32'(ana_pd_req), 32'd3);
    c1 = cyc;
    wait_vld(30);
    check("p01_req", 32'(ana_pd_req), 32'd1);
    ack_seq(2, 2, n);
    check("p01_cur",    32'(cur_pd),       32'd1);
    check("p01_toggle", 32'(pwr_chg_done), 32'd0);
    check("done_gap_ok", 32'(cyc - c1 >= MIN_GAP), 32'd1);
    repeat (MIN_GAP) step();
    check("p01_idle", 32'(pwr_chg_busy), 32'd0);

    // Ack never rises
    pipe_powerdown = 2'b00;
    step();
    check("tmo_vld", 32'(ana_pd_req_vld), 32'd1);
`ifdef MP_PWR_CHG_ACK_TMO_EN
    repeat (ACK_TMO - 1) step();
    check("tmo_pre_err", 32'(ack_tmo_err),    32'd0);
    check("tmo_pre_vld", 32'(ana_pd_req_vld), 32'd1);
    step();
    check("tmo_err",    32'(ack_tmo_err),    32'd1);
    check("tmo_vld0",   32'(ana_pd_req_vld), 32'd0);
    check("tmo_toggle", 32'(pwr_chg_done),   32'd1);
    check("tmo_cur",    32'(cur_pd),         32'd0);
    repeat (MIN_GAP) step();
    check("tmo_sticky", 32'(ack_tmo_err),  32'd1);
    check("tmo_idle",   32'(pwr_chg_busy), 32'd0);
`else
    repeat (40) step();
    check("hang_vld",  32'(ana_pd_req_vld), 32'd1);
    check("hang_busy", 32'(pwr_chg_busy),   32'd1);
    check("hang_err",  32'(ack_tmo_err),    32'd0);
    check("hang_done", 32'(pwr_chg_done),   32'd0);
    check("hang_cur",  32'(cur_pd),         32'd1);
    ack_seq(1, 1, n);
    check("late_cur",    32'(cur_pd),       32'd0);
    check("late_toggle", 32'(pwr_chg_done), 32'd1);
    repeat (MIN_GAP) step();
    check("late_idle", 32'(pwr_chg_busy), 32'd0);
`endif

    // Reset in the middle of a handshake
    pipe_powerdown = 2'b11;
    step();
    check("mid_vld", 32'(ana_pd_req_vld), 32'd1);
    #2;
    psm_rst_n = 1'b0;
    #1;
    check("mid_rst_vld",  32'(ana_pd_req_vld), 32'd0);
    check("mid_rst_req",  32'(ana_pd_req),     32'(PD_RST));
    check("mid_rst_cur",  32'(cur_pd),         32'(PD_RST));
    check("mid_rst_busy", 32'(pwr_chg_busy),   32'd0);
    check("mid_rst_done", 32'(pwr_chg_done),   32'd0);
    check("mid_rst_err",  32'(ack_tmo_err),    32'd0);
    @(negedge psm_clk);
    psm_rst_n = 1'b1;
    step();
    check("re_cur_follow", 32'(cur_pd), 32'd3);
    repeat (5) step();
    check("re_done_wait", 32'(pwr_chg_done),   32'd0);
    check("re_no_hs",     32'(ana_pd_req_vld), 32'd0);
    lane_startup_done = 1'b1;
    step();
    check("re_done_rise", 32'(pwr_chg_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
